// File: rtl/ad_pkg.sv
// Shared definitions for the ADC serial link blocks.
// The frame receiver, the sclk generator and ad_top all use these.
package ad_pkg;

    localparam int AD_DATA_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE,
        GAP   = ST_GAP
    } ad_state_t;

endpackage

// File: rtl/ad_shift_in.sv
// Serial-in shift register with a parallel output register.
// The output register is loaded with the word that includes the bit being shifted in.
module ad_shift_in
    import ad_pkg::*;
#(
    parameter int DATA_W = AD_DATA_W
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              load_en,
    input  logic              sdata,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shift_next;

    assign shift_next = {shreg[DATA_W-2:0], sdata};

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            data_out <= '0;
        end else begin
            if (shift_en) begin
                shreg <= shift_next;
            end
            if (load_en) begin
                data_out <= shift_next;
            end
        end
    end

endmodule

// File: rtl/ad_frame_rx.sv
// Frames one ADC conversion read: cs_n setup, DATA_W MSB-first samples on pluse, then a cs_n-high gap.
// All sequencing runs in clk_sys; pluse marks each sclk period.
module ad_frame_rx
    import ad_pkg::*;
#(
    parameter int DATA_W    = AD_DATA_W,
    parameter int SETUP_PLS = 2,
    parameter int GAP_PLS   = 4
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pluse,
    input  logic              sdata,
    output logic              cs_n,
    output logic              sclk_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              busy,
    output logic              err_ovr
);

    localparam int BW = $clog2(DATA_W) + 1;

    ad_state_t state, state_nxt;
    logic [3:0]    pls_cnt, pls_cnt_nxt;
    logic [BW-1:0] bit_cnt, bit_cnt_nxt;
    logic          shift_en, load_en;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pls_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pls_cnt <= pls_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // A pluse coinciding with start is not counted: IDLE only moves to SETUP.
    always_comb begin
        state_nxt   = state;
        pls_cnt_nxt = pls_cnt;
        bit_cnt_nxt = bit_cnt;
        shift_en    = 1'b0;
        load_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SETUP;
                    pls_cnt_nxt = '0;
                end
            end
            SETUP: begin
                if (pluse) begin
                    if (pls_cnt == 4'(SETUP_PLS - 1)) begin
                        state_nxt   = SHIFT;
                        pls_cnt_nxt = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        pls_cnt_nxt = pls_cnt + 4'd1;
                    end
                end
            end
            SHIFT: begin
                if (pluse) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BW'(DATA_W - 1)) begin
                        load_en     = 1'b1;
                        state_nxt   = DONE;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt   = GAP;
                pls_cnt_nxt = '0;
            end
            GAP: begin
                if (pluse) begin
                    if (pls_cnt == 4'(GAP_PLS - 1)) begin
                        state_nxt   = IDLE;
                        pls_cnt_nxt = '0;
                    end else begin
                        pls_cnt_nxt = pls_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cs_n     <= 1'b1;
            sclk_en  <= 1'b0;
            data_vld <= 1'b0;
            busy     <= 1'b0;
            err_ovr  <= 1'b0;
        end else begin
            cs_n     <= !((state_nxt == SETUP) || (state_nxt == SHIFT));
            sclk_en  <= (state_nxt == SHIFT);
            data_vld <= (state_nxt == DONE);
            busy     <= (state_nxt != IDLE);
            err_ovr  <= start && (state != IDLE);
        end
    end

    ad_shift_in #(
        .DATA_W(DATA_W)
    ) u_shift_in (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .shift_en(shift_en),
        .load_en (load_en),
        .sdata   (sdata),
        .data_out(data_out)
    );

endmodule

// File: tb/tb_ad_frame_rx.sv
// Bench for ad_frame_rx: per-cycle reference model driven by pluse counts since start,
// a vector table of whole frames, directed corner sequences and randomized traffic.
module tb_ad_frame_rx;

    localparam int DATA_W = 16;
    localparam int S      = 2;
    localparam int G      = 4;

    logic              clk_sys = 1'b0;
    logic              rst_n   = 1'b0;
    logic              start   = 1'b0;
    logic              pluse   = 1'b0;
    logic              sdata   = 1'b0;
    logic              cs_n;
    logic              sclk_en;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              busy;
    logic              err_ovr;

    ad_frame_rx #(
        .DATA_W(DATA_W),
        .SETUP_PLS(S),
        .GAP_PLS(G)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .start   (start),
        .pluse   (pluse),
        .sdata   (sdata),
        .cs_n    (cs_n),
        .sclk_en (sclk_en),
        .data_out(data_out),
        .data_vld(data_vld),
        .busy    (busy),
        .err_ovr (err_ovr)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, required to have finished");
        $fatal(1, "[TB] watchdog");
    end

    int errors = 0;
    int checks = 0;

    int div = 2;
    int ph  = 0;
    logic [DATA_W-1:0] cur_word = '0;

    // Reference model: a frame is described purely by how many pluses have been seen since start.
    bit                m_busy = 1'b0;
    bit                m_done = 1'b0;
    bit                m_vld  = 1'b0;
    bit                m_err  = 1'b0;
    int                m_k    = 0;
    int                m_gk   = 0;
    logic [DATA_W-1:0] m_bits = '0;
    logic [DATA_W-1:0] m_dout = '0;

    typedef struct {
        logic [DATA_W-1:0] word;
        int                dv;
        bit                pl_start;
        logic [DATA_W-1:0] exp_word;
        int                exp_vld;
        int                exp_cs_pls;
    } vec_t;

    vec_t vecs[7];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_vld  = 1'b0;
        m_err  = 1'b0;
        m_k    = 0;
        m_gk   = 0;
        m_bits = '0;
        m_dout = '0;
    endtask

    task automatic model_edge(input bit st, input bit pl, input bit sd);
        m_vld = 1'b0;
        m_err = st && m_busy;
        if (!m_busy) begin
            if (st) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_gk   = 0;
                m_done = 1'b0;
                m_bits = '0;
            end
        end else if (m_k < S + DATA_W) begin
            if (pl) begin
                m_k++;
                if (m_k > S) m_bits = {m_bits[DATA_W-2:0], sd};
                if (m_k == S + DATA_W) begin
                    m_vld  = 1'b1;
                    m_dout = m_bits;
                    m_done = 1'b1;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (pl) begin
            m_gk++;
            if (m_gk == G) m_busy = 1'b0;
        end
    endtask

    task automatic check_output();
        check1("cs_n",     32'(cs_n),     32'(!(m_busy && m_k < S + DATA_W)));
        check1("sclk_en",  32'(sclk_en),  32'(m_busy && m_k >= S && m_k < S + DATA_W));
        check1("busy",     32'(busy),     32'(m_busy));
        check1("data_vld", 32'(data_vld), 32'(m_vld));
        check1("err_ovr",  32'(err_ovr),  32'(m_err));
        check1("data_out", 32'(data_out), 32'(m_dout));
    endtask

    // Drives one cycle of inputs after a negedge, updates the model at the posedge, checks at the next negedge.
    task automatic apply_stimulus(input bit st, input bit force_pl, output bit pl);
        bit sd;
        if (force_pl) begin
            ph = 0;
            pl = 1'b1;
        end else begin
            ph = (ph + 1) % div;
            pl = (ph == 0);
        end
        if (m_busy && !m_done && pl && m_k >= S && m_k < S + DATA_W)
            sd = cur_word[DATA_W-1-(m_k-S)];
        else
            sd = 1'($urandom_range(0, 1));
        start = st;
        pluse = pl;
        sdata = sd;
        @(posedge clk_sys);
        model_edge(st, pl, sd);
        @(negedge clk_sys);
        check_output();
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] w, input int dv, input bit pl_st,
                             output logic [DATA_W-1:0] got, output int vlds,
                             output int cs_pls, output int gap_pls);
        bit   p;
        bit   seen;
        logic cs_before;
        cur_word = w;
        div      = dv;
        vlds     = 0;
        cs_pls   = 0;
        gap_pls  = 0;
        got      = '0;
        seen     = 1'b0;
        apply_stimulus(1'b1, pl_st, p);
        for (int i = 0; i < 2000; i++) begin
            if (data_vld) begin
                vlds++;
                got  = data_out;
                seen = 1'b1;
            end
            if (!m_busy) break;
            cs_before = cs_n;
            apply_stimulus(1'b0, 1'b0, p);
            if (p && !cs_before) cs_pls++;
            if (p && cs_before && seen) gap_pls++;
        end
        check1("frame_timeout", 32'(m_busy), 32'd0);
    endtask

    task automatic do_reset();
        start = 1'b0;
        pluse = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check1("rst_cs_n",     32'(cs_n),     32'd1);
        check1("rst_sclk_en",  32'(sclk_en),  32'd0);
        check1("rst_busy",     32'(busy),     32'd0);
        check1("rst_data_vld", 32'(data_vld), 32'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] got;
        int  vlds, cs_pls, gap_pls, errs_seen, ncyc;
        bit  p;

        vecs[0] = '{word: 16'hA5C3, dv: 2, pl_start: 1'b0, exp_word: 16'hA5C3, exp_vld: 1, exp_cs_pls: S + DATA_W};
        vecs[1] = '{word: 16'hFFFF, dv: 2, pl_start: 1'b0, exp_word: 16'hFFFF, exp_vld: 1, exp_cs_pls: S + DATA_W};
        vecs[2] = '{word: 16'h0001, dv: 2, pl_start: 1'b0, exp_word: 16'h0001, exp_vld: 1, exp_cs_pls: S + DATA_W};
        vecs[3] = '{word: 16'h1234, dv: 2, pl_start: 1'b1, exp_word: 16'h1234, exp_vld: 1, exp_cs_pls: S + DATA_W};
        vecs[4] = '{word: 16'h8001, dv: 4, pl_start: 1'b1, exp_word: 16'h8001, exp_vld: 1, exp_cs_pls: S + DATA_W};
        vecs[5] = '{word: 16'h0000, dv: 3, pl_start: 1'b0, exp_word: 16'h0000, exp_vld: 1, exp_cs_pls: S + DATA_W};
        vecs[6] = '{word: 16'h5A3C, dv: 4, pl_start: 1'b0, exp_word: 16'h5A3C, exp_vld: 1, exp_cs_pls: S + DATA_W};

        model_reset();
        repeat (3) @(negedge clk_sys);
        check_output();
        rst_n = 1'b1;

        $display("[TB] idle with pluse toggling");
        div = 2;
        for (int i = 0; i < 50; i++) apply_stimulus(1'b0, 1'b0, p);

        $display("[TB] vector table (entries 1 and 2 run back-to-back)");
        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].word, vecs[v].dv, vecs[v].pl_start, got, vlds, cs_pls, gap_pls);
            check1($sformatf("vec%0d_word", v),   32'(got),    32'(vecs[v].exp_word));
            check1($sformatf("vec%0d_vld", v),    32'(vlds),   32'(vecs[v].exp_vld));
            check1($sformatf("vec%0d_cs_pls", v), 32'(cs_pls), 32'(vecs[v].exp_cs_pls));
            check1($sformatf("vec%0d_gap_min", v), 32'(gap_pls >= G), 32'd1);
        end

        $display("[TB] start while busy");
        cur_word  = 16'hA5C3;
        div       = 2;
        vlds      = 0;
        errs_seen = 0;
        got       = '0;
        apply_stimulus(1'b1, 1'b0, p);
        apply_stimulus(1'b0, 1'b0, p);
        apply_stimulus(1'b0, 1'b0, p);
        apply_stimulus(1'b1, 1'b0, p);
        for (int i = 0; i < 2000; i++) begin
            if (err_ovr) errs_seen++;
            if (data_vld) begin
                vlds++;
                got = data_out;
            end
            if (!m_busy) break;
            apply_stimulus(1'b0, 1'b0, p);
        end
        check1("ovr_err_pulses", 32'(errs_seen), 32'd1);
        check1("ovr_vld_count",  32'(vlds),      32'd1);
        check1("ovr_word",       32'(got),       32'hA5C3);
        repeat (20) apply_stimulus(1'b0, 1'b0, p);

        $display("[TB] reset during bit 7");
        cur_word = 16'hFFFF;
        div      = 2;
        apply_stimulus(1'b1, 1'b0, p);
        for (int i = 0; i < 200 && m_k != S + 7; i++) apply_stimulus(1'b0, 1'b0, p);
        check1("reached_bit7", 32'(m_k), 32'(S + 7));
        do_reset();
        repeat (5) apply_stimulus(1'b0, 1'b0, p);
        run_frame(16'h1234, 2, 1'b0, got, vlds, cs_pls, gap_pls);
        check1("post_rst_word", 32'(got),  32'h1234);
        check1("post_rst_vld",  32'(vlds), 32'd1);

        $display("[TB] randomized traffic");
        for (int r = 0; r < 40; r++) begin
            div  = int'($urandom_range(2, 4));
            ncyc = int'($urandom_range(20, 120));
            for (int c = 0; c < ncyc; c++) begin
                if (!m_busy) cur_word = DATA_W'($urandom);
                apply_stimulus(($urandom_range(0, 7) == 0), 1'b0, p);
            end
        end
        for (int i = 0; i < 2000 && m_busy; i++) apply_stimulus(1'b0, 1'b0, p);
        check1("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
